// File: rtl/register_file_mp.sv
// Multi-port integer register file: NUM_READ combinational read ports, two write
// ports (A: writeback, B: load/late, B wins on collision), optional hard-wired
// zero register, optional write-to-read bypass, and a one-word-per-cycle clear
// sequencer (IDLE -> CLEAR -> DONE -> IDLE).
module register_file_mp #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_READ   = 2,
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned BYPASS     = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr_i,
   output logic [NUM_READ*DATA_WIDTH-1:0] rdata_o,
   input  logic [ADDR_WIDTH-1:0]          waddr_a_i,
   input  logic [DATA_WIDTH-1:0]          wdata_a_i,
   input  logic                           we_a_i,
   input  logic [ADDR_WIDTH-1:0]          waddr_b_i,
   input  logic [DATA_WIDTH-1:0]          wdata_b_i,
   input  logic                           we_b_i,
   input  logic                           clr_req_i,
   output logic                           clr_busy_o,
   output logic                           clr_done_o
);

   localparam int unsigned           NUM_WORDS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic [ADDR_WIDTH-1:0]   cnt_d;

   // Effective per-cycle actions decoded from the current state.
   logic                    wr_en_a_c;
   logic                    wr_en_b_c;
   logic                    clr_en_c;

   // Flattened view of the storage array for the read muxes.
   logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem_c;

   // State, counter and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         clr_busy_o <= 1'b0;
         clr_done_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clr_busy_o <= (state_d == ST_CLEAR);
         clr_done_o <= (state_d == ST_DONE);
      end
   end

   // Next-state and clear-counter logic; the counter saturates at the last word.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_req_i) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Per-state actions: writes are live outside CLEAR, clearing only inside it.
   always_comb begin
      wr_en_a_c = 1'b0;
      wr_en_b_c = 1'b0;
      clr_en_c  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            wr_en_a_c = we_a_i;
            wr_en_b_c = we_b_i;
         end
         ST_CLEAR: begin
            clr_en_c = 1'b1;
         end
         default: begin
            wr_en_a_c = 1'b0;
         end
      endcase
   end

   // Storage words; word 0 is never written when it is the hard-wired zero.
   for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
      localparam logic [ADDR_WIDTH-1:0] WADDR    = ADDR_WIDTH'(w);
      localparam bit                    WRITABLE = !((ZERO_REG != 0) && (w == 0));

      logic                  hit_a_c;
      logic                  hit_b_c;
      logic                  hit_clr_c;
      logic [DATA_WIDTH-1:0] word_q;

      assign hit_a_c   = WRITABLE && wr_en_a_c && (waddr_a_i == WADDR);
      assign hit_b_c   = WRITABLE && wr_en_b_c && (waddr_b_i == WADDR);
      assign hit_clr_c = clr_en_c && (cnt_q == WADDR);

      // Clear has priority, then port B, then port A.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            word_q <= '0;
         end else if (hit_clr_c) begin
            word_q <= '0;
         end else if (hit_b_c) begin
            word_q <= wdata_b_i;
         end else if (hit_a_c) begin
            word_q <= wdata_a_i;
         end
      end

      assign mem_c[w] = word_q;
   end

   // Read ports: array lookup, optional same-cycle bypass, zero-register override.
   for (genvar k = 0; k < NUM_READ; k++) begin : g_read
      logic [ADDR_WIDTH-1:0] ra_c;
      logic [DATA_WIDTH-1:0] rd_c;

      assign ra_c = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];

      // Bypass only sees writes that will actually land (never during CLEAR).
      always_comb begin
         rd_c = mem_c[ra_c];
         if (BYPASS != 0) begin
            if (wr_en_b_c && (waddr_b_i == ra_c)) begin
               rd_c = wdata_b_i;
            end else if (wr_en_a_c && (waddr_a_i == ra_c)) begin
               rd_c = wdata_a_i;
            end
         end
         if ((ZERO_REG != 0) && (ra_c == '0)) begin
            rd_c = '0;
         end
      end

      assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rd_c;
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: two instances share all inputs,
// dut_z (ZERO_REG=1, BYPASS=0) and dut_b (ZERO_REG=0, BYPASS=1).
`timescale 1ns/1ps
module tb_register_file_mp;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned NR = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata_z;
   logic [NR*DW-1:0] rdata_b;
   logic [AW-1:0]    waddr_a;
   logic [DW-1:0]    wdata_a;
   logic             we_a;
   logic [AW-1:0]    waddr_b;
   logic [DW-1:0]    wdata_b;
   logic             we_b;
   logic             clr_req;
   logic             busy_z, done_z, busy_b, done_b;

   always #5 clk = ~clk;

   register_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR),
                      .ZERO_REG(1), .BYPASS(0)) dut_z (
      .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_z),
      .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
      .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
      .clr_req_i(clr_req), .clr_busy_o(busy_z), .clr_done_o(done_z));

   register_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR),
                      .ZERO_REG(0), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_b),
      .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
      .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
      .clr_req_i(clr_req), .clr_busy_o(busy_b), .clr_done_o(done_b));

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic          we_a;
      logic [AW-1:0] wa_a;
      logic [DW-1:0] wd_a;
      logic          we_b;
      logic [AW-1:0] wa_b;
      logic [DW-1:0] wd_b;
      logic [AW-1:0] ra0;
      logic [AW-1:0] ra1;
      logic [DW-1:0] e0_z;
      logic [DW-1:0] e1_z;
      logic [DW-1:0] e0_b;
      logic [DW-1:0] e1_b;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [DW-1:0] port(input logic [NR*DW-1:0] v, input int k);
      return v[k*DW +: DW];
   endfunction

   task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      raddr = {a1, a0};
   endtask

   // Read every word on both ports; word 'special' is expected to hold 'sval'.
   task automatic check_all(input string tag, input logic [AW-1:0] special, input logic [DW-1:0] sval);
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      for (int a = 0; a < 32; a++) begin
         @(negedge clk);
         a0 = AW'(a);
         a1 = AW'(31 - a);
         set_raddr(a0, a1);
         #1;
         check($sformatf("%s_z_p0_a%0d", tag, a0), port(rdata_z, 0), (a0 == special) ? sval : '0);
         check($sformatf("%s_z_p1_a%0d", tag, a1), port(rdata_z, 1), (a1 == special) ? sval : '0);
         check($sformatf("%s_b_p0_a%0d", tag, a0), port(rdata_b, 0), (a0 == special) ? sval : '0);
         check($sformatf("%s_b_p1_a%0d", tag, a1), port(rdata_b, 1), (a1 == special) ? sval : '0);
      end
   endtask

   // Word a <= a, using both write ports (16 cycles).
   task automatic fill_all();
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         we_a = 1'b1; waddr_a = AW'(a);      wdata_a = DW'(a);
         we_b = 1'b1; waddr_b = AW'(a + 16); wdata_b = DW'(a + 16);
      end
      @(negedge clk);
      we_a = 1'b0;
      we_b = 1'b0;
   endtask

   // Pulse clr_req and walk the sequence; mode 0 = full fill test, mode 1 = restart test.
   task automatic run_clear(input int mode);
      int busy_n  = 0;
      int done_n  = 0;
      int busy_nb = 0;
      int done_nb = 0;
      bit ended   = 1'b0;
      @(negedge clk);
      clr_req = 1'b1;
      for (int c = 0; c < 200 && !ended; c++) begin
         @(negedge clk);
         #1;
         clr_req = 1'b0;
         we_a    = 1'b0;
         if (busy_b) busy_nb++;
         if (done_b) done_nb++;
         if (busy_z) begin
            if (mode == 0 && busy_n == 10) begin
               set_raddr(5'd20, 5'd2);
               we_a = 1'b1; waddr_a = 5'd2; wdata_a = 32'h55;
               #1;
               check("mid_clr_z_uncleared", port(rdata_z, 0), 32'd20);
               check("mid_clr_z_cleared",   port(rdata_z, 1), 32'd0);
               check("mid_clr_b_uncleared", port(rdata_b, 0), 32'd20);
               check("mid_clr_b_nobypass",  port(rdata_b, 1), 32'd0);
            end
            if (mode == 0 && busy_n == 11) begin
               set_raddr(5'd10, 5'd2);
               #1;
               check("mid_clr_z_cnt10",   port(rdata_z, 0), 32'd0);
               check("mid_clr_z_dropped", port(rdata_z, 1), 32'd0);
               check("mid_clr_b_dropped", port(rdata_b, 1), 32'd0);
            end
            if (mode == 0 && busy_n == 20) clr_req = 1'b1;
            if (mode == 1 && busy_n == 1) begin
               set_raddr(5'd1, 5'd31);
               #1;
               check("restart_z_w1_pending", port(rdata_z, 0), 32'h11);
               check("restart_b_w31",        port(rdata_b, 1), 32'h31);
            end
            if (mode == 1 && busy_n == 2) begin
               set_raddr(5'd1, 5'd31);
               #1;
               check("restart_z_w1_cleared", port(rdata_z, 0), 32'h0);
               check("restart_z_w31_pending", port(rdata_z, 1), 32'h31);
            end
            busy_n++;
         end else if (done_z) begin
            done_n++;
            if (mode == 0) begin
               we_a = 1'b1; waddr_a = 5'd6; wdata_a = 32'h66;
            end
         end else if (busy_n > 0 || done_n > 0) begin
            ended = 1'b1;
            if (mode == 0) begin
               set_raddr(5'd6, 5'd6);
               #1;
               check("done_write_z", port(rdata_z, 0), 32'h66);
               check("done_write_b", port(rdata_b, 1), 32'h66);
            end
         end
      end
      we_a    = 1'b0;
      clr_req = 1'b0;
      check($sformatf("clr_busy_cycles_z_m%0d", mode), DW'(busy_n),  32'd32);
      check($sformatf("clr_done_cycles_z_m%0d", mode), DW'(done_n),  32'd1);
      check($sformatf("clr_busy_cycles_b_m%0d", mode), DW'(busy_nb), 32'd32);
      check($sformatf("clr_done_cycles_b_m%0d", mode), DW'(done_nb), 32'd1);
      check($sformatf("clr_ended_m%0d", mode),         DW'(ended),   32'd1);
   endtask

   initial begin
      bit seen;
      //          we_a  wa_a   wd_a          we_b  wa_b   wd_b      ra0    ra1    e0_z          e1_z          e0_b          e1_b
      vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    5'd5, 5'd0, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0};
      vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
      vecs[2]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,    5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 32'h1234,     32'hDEADBEEF};
      vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 32'h0,        32'h0,        32'h1234,     32'h1234};
      vecs[4]  = '{1'b1, 5'd7, 32'h1111,     1'b1, 5'd7, 32'h2222, 5'd7, 5'd7, 32'h0,        32'h0,        32'h2222,     32'h2222};
      vecs[5]  = '{1'b1, 5'd3, 32'hA,        1'b1, 5'd4, 32'hB,    5'd7, 5'd3, 32'h2222,     32'h0,        32'h2222,     32'hA};
      vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd3, 5'd4, 32'hA,        32'hB,        32'hA,        32'hB};
      vecs[7]  = '{1'b1, 5'd9, 32'hCAFE,     1'b0, 5'd0, 32'h0,    5'd9, 5'd4, 32'h0,        32'hB,        32'hCAFE,     32'hB};
      vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd9, 5'd9, 32'hCAFE,     32'hCAFE,     32'hCAFE,     32'hCAFE};
      vecs[9]  = '{1'b1, 5'd0, 32'h66,       1'b1, 5'd0, 32'h77,   5'd0, 5'd3, 32'h0,        32'hA,        32'h77,       32'hA};
      vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd0, 5'd7, 32'h0,        32'h2222,     32'h77,       32'h2222};

      rst = 1'b1;
      raddr = '0;
      we_a = 1'b0; waddr_a = '0; wdata_a = '0;
      we_b = 1'b0; waddr_b = '0; wdata_b = '0;
      clr_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_busy_z", DW'(busy_z), 32'd0);
      check("rst_done_z", DW'(done_z), 32'd0);
      check("rst_busy_b", DW'(busy_b), 32'd0);
      check("rst_done_b", DW'(done_b), 32'd0);
      check_all("rst", 5'd0, 32'h0);

      // Single-cycle vectors: outputs checked within the cycle, before the write edge.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         we_a = vecs[i].we_a; waddr_a = vecs[i].wa_a; wdata_a = vecs[i].wd_a;
         we_b = vecs[i].we_b; waddr_b = vecs[i].wa_b; wdata_b = vecs[i].wd_b;
         set_raddr(vecs[i].ra0, vecs[i].ra1);
         #1;
         check($sformatf("vec%0d_z_p0", i), port(rdata_z, 0), vecs[i].e0_z);
         check($sformatf("vec%0d_z_p1", i), port(rdata_z, 1), vecs[i].e1_z);
         check($sformatf("vec%0d_b_p0", i), port(rdata_b, 0), vecs[i].e0_b);
         check($sformatf("vec%0d_b_p1", i), port(rdata_b, 1), vecs[i].e1_b);
         check($sformatf("vec%0d_busy", i), DW'(busy_z), 32'd0);
      end
      @(negedge clk);
      we_a = 1'b0;
      we_b = 1'b0;

      // Full clear after filling every word with its address.
      fill_all();
      set_raddr(5'd17, 5'd30);
      #1;
      check("fill_z_a17", port(rdata_z, 0), 32'd17);
      check("fill_b_a30", port(rdata_b, 1), 32'd30);
      run_clear(0);
      check_all("post_clr", 5'd6, 32'h66);

      // Reset in the middle of a clear.
      fill_all();
      @(negedge clk);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      check("pre_rst_busy_z", DW'(busy_z), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy_z", DW'(busy_z), 32'd0);
      check("mid_rst_done_z", DW'(done_z), 32'd0);
      check("mid_rst_busy_b", DW'(busy_b), 32'd0);
      set_raddr(5'd20, 5'd31);
      #1;
      check("mid_rst_z_a20", port(rdata_z, 0), 32'h0);
      check("mid_rst_b_a31", port(rdata_b, 1), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         #1;
         if (done_z || done_b || busy_z || busy_b) seen = 1'b1;
      end
      check("no_done_after_rst", DW'(seen), 32'd0);
      check_all("after_rst", 5'd0, 32'h0);

      // Next clear must start again from word 0.
      @(negedge clk);
      we_a = 1'b1; waddr_a = 5'd1;  wdata_a = 32'h11;
      we_b = 1'b1; waddr_b = 5'd31; wdata_b = 32'h31;
      @(negedge clk);
      we_a = 1'b0;
      we_b = 1'b0;
      run_clear(1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
